// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among REQ_NUM requesters.
// A grant lasts up to BURST transfers, and each new grant costs one IDLE arbitration cycle.
module fifo_wr_arbiter #(
   parameter int DWIDTH  = 8,
   parameter int REQ_NUM = 4,
   parameter int BURST   = 4
) (
   input  logic                        clk_i,
   input  logic                        srst_i,
   input  logic [REQ_NUM-1:0]          req_valid_i,
   input  logic [REQ_NUM*DWIDTH-1:0]   req_data_i,
   output logic [REQ_NUM-1:0]          req_ready_o,
   input  logic                        fifo_full_i,
   output logic                        fifo_wr_req_o,
   output logic [DWIDTH-1:0]           fifo_data_o,
   output logic [REQ_NUM-1:0]          grant_o,
   output logic                        busy_o
);

   localparam int BWIDTH = $clog2(BURST + 1);
   localparam int PWIDTH = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t              state;
   logic [PWIDTH-1:0]   rr_ptr;
   logic [PWIDTH-1:0]   owner;
   logic [BWIDTH-1:0]   beat_cnt;

   logic [PWIDTH-1:0]   pick;
   logic                any_valid;
   logic [PWIDTH-1:0]   next_ptr;
   logic                owner_valid;
   logic                active;
   logic                transfer;
   logic                last_beat;

   // Scan rr_ptr, rr_ptr+1, ... (mod REQ_NUM) and keep the first valid index.
   always_comb begin
      int unsigned idx;
      idx       = 0;
      pick      = rr_ptr;
      any_valid = 1'b0;
      for (int unsigned i = 0; i < REQ_NUM; i++) begin
         idx = (int'(rr_ptr) + i) % REQ_NUM;
         if (!any_valid && req_valid_i[PWIDTH'(idx)]) begin
            any_valid = 1'b1;
            pick      = PWIDTH'(idx);
         end
      end
   end

   always_comb begin
      next_ptr    = (owner == PWIDTH'(REQ_NUM - 1)) ? '0 : owner + 1'b1;
      owner_valid = req_valid_i[owner];
      // Reset gates the write path combinationally so the reset edge itself never writes.
      active      = (state == GRANT) && !srst_i;
      transfer    = active && owner_valid && !fifo_full_i;
      last_beat   = (beat_cnt == BWIDTH'(BURST - 1));
   end

   always_comb begin
      req_ready_o   = '0;
      fifo_wr_req_o = transfer;
      fifo_data_o   = '0;
      if (active) begin
         req_ready_o[owner] = !fifo_full_i;
         fifo_data_o        = req_data_i[owner*DWIDTH +: DWIDTH];
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         owner    <= '0;
         beat_cnt <= '0;
         grant_o  <= '0;
         busy_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  state       <= GRANT;
                  owner       <= pick;
                  beat_cnt    <= '0;
                  grant_o     <= '0;
                  grant_o[pick] <= 1'b1;
                  busy_o      <= 1'b1;
               end
            end
            GRANT: begin
               // Full-stall cycles neither count nor release; valid low only releases when not full.
               if ((transfer && last_beat) || (!fifo_full_i && !owner_valid)) begin
                  state    <= IDLE;
                  rr_ptr   <= next_ptr;
                  beat_cnt <= '0;
                  grant_o  <= '0;
                  busy_o   <= 1'b0;
               end else if (transfer) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               grant_o <= '0;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with an 8-deep FIFO model and a write log.
// Requester k sends words {k[1:0], n[5:0]} with n counting its accepted transfers.
module tb_fifo_wr_arbiter;

   localparam int DW = 8;
   localparam int RN = 4;
   localparam int BU = 4;

   logic            clk = 1'b0;
   logic            srst;
   logic [RN-1:0]   valid;
   logic [RN*DW-1:0] data;
   logic [RN-1:0]   ready;
   logic            full;
   logic            wr_req;
   logic [DW-1:0]   fdata;
   logic [RN-1:0]   grant;
   logic            busy;

   logic [5:0]      seq [RN] = '{default: 6'd0};
   logic [DW-1:0]   mem  [$];
   logic [DW-1:0]   wlog [$];
   logic [DW-1:0]   rlog [$];
   int              cnt = 0;
   logic            pop_en;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   fifo_wr_arbiter #(.DWIDTH(DW), .REQ_NUM(RN), .BURST(BU)) dut (
      .clk_i        (clk),
      .srst_i       (srst),
      .req_valid_i  (valid),
      .req_data_i   (data),
      .req_ready_o  (ready),
      .fifo_full_i  (full),
      .fifo_wr_req_o(wr_req),
      .fifo_data_o  (fdata),
      .grant_o      (grant),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   assign full = (cnt >= 8);

   always_comb begin
      data = '0;
      for (int k = 0; k < RN; k++) data[k*DW +: DW] = {2'(k), seq[k]};
   end

   always @(posedge clk) begin
      if (pop_en && cnt > 0) rlog.push_back(mem.pop_front());
      if (wr_req) begin
         mem.push_back(fdata);
         wlog.push_back(fdata);
      end
      cnt <= cnt + (wr_req ? 1 : 0) - ((pop_en && cnt > 0) ? 1 : 0);
      for (int k = 0; k < RN; k++)
         if (valid[k] && ready[k]) seq[k] <= seq[k] + 6'd1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called right after a grant edge; checks n write cycles of requester k from word base.
   task automatic burst(input int k, input int n, input int base, input bit full_burst);
      chk("grant", 32'(grant), 32'(1 << k));
      chk("busy", 32'(busy), 32'd1);
      for (int i = 0; i < n; i++) begin
         chk("wr_req", 32'(wr_req), 32'd1);
         chk("data", 32'(fdata), 32'(k*64 + base + i));
         chk("ready", 32'(ready), 32'(1 << k));
         step();
      end
      if (full_burst) begin
         chk("idle_grant", 32'(grant), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_wr_req", 32'(wr_req), 32'd0);
         chk("idle_data", 32'(fdata), 32'd0);
      end
   endtask

   initial begin
      int n0;
      int rstart;

      // 1: reset with all valids high
      srst = 1'b1;
      valid = '1;
      pop_en = 1'b1;
      for (int r = 0; r < 2; r++) begin
         step();
         chk("rst_ready", 32'(ready), 32'd0);
         chk("rst_wr_req", 32'(wr_req), 32'd0);
         chk("rst_data", 32'(fdata), 32'd0);
         chk("rst_grant", 32'(grant), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
      end
      srst = 1'b0;
      #1;
      chk("post_rst_wr_req", 32'(wr_req), 32'd0);
      step();
      chk("no_write_1st_edge", 32'(wlog.size()), 32'd0);

      // 2: all requesters valid, order 0,1,2,3,0
      burst(0, 4, 0, 1'b1);
      chk("wlog_after_r0", 32'(wlog.size()), 32'd4);
      step(); burst(1, 4, 0, 1'b1);
      step(); burst(2, 4, 0, 1'b1);
      step(); burst(3, 4, 0, 1'b1);
      step(); burst(0, 4, 4, 1'b1);
      for (int i = 0; i < 8; i++)
         chk("first8", 32'(wlog[i]), (i < 4) ? 32'(i) : 32'(64 + i - 4));

      // 3: only requester 2, 10 words in groups 4,4,2
      valid = 4'b0100;
      step(); burst(2, 4, 4, 1'b1);
      step(); burst(2, 4, 8, 1'b1);
      step(); burst(2, 2, 12, 1'b0);
      valid = 4'b0000;
      #1;
      chk("r2_drop_wr_req", 32'(wr_req), 32'd0);
      chk("r2_drop_grant", 32'(grant), 32'b0100);
      step();
      chk("r2_rel_grant", 32'(grant), 32'd0);
      chk("r2_rr_ptr", 32'(dut.rr_ptr), 32'd3);

      // 4: requester 1 drops after 2 words while 3 waits
      valid = 4'b1010;
      step(); burst(3, 4, 4, 1'b1);
      step(); burst(1, 2, 4, 1'b0);
      valid = 4'b1000;
      #1;
      chk("r1_drop_wr_req", 32'(wr_req), 32'd0);
      step();
      chk("r1_rel_grant", 32'(grant), 32'd0);
      chk("r1_rr_ptr", 32'(dut.rr_ptr), 32'd2);
      step(); burst(3, 4, 8, 1'b1);
      valid = 4'b0000;

      // 5: fill FIFO, hold full, then release one slot
      step(); step();
      chk("drained", 32'(cnt), 32'd0);
      rstart = rlog.size();
      pop_en = 1'b0;
      valid = 4'b0001;
      step(); burst(0, 4, 8, 1'b1);
      step(); burst(0, 4, 12, 1'b1);
      chk("fifo_full", 32'(full), 32'd1);
      step();
      chk("full_grant", 32'(grant), 32'b0001);
      chk("full_wr_req", 32'(wr_req), 32'd0);
      chk("full_ready", 32'(ready), 32'd0);
      n0 = wlog.size();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_wr_req", 32'(wr_req), 32'd0);
         chk("hold_grant", 32'(grant), 32'b0001);
         chk("hold_wlog", 32'(wlog.size()), 32'(n0));
      end
      pop_en = 1'b1;
      step();
      pop_en = 1'b0;
      chk("unfull", 32'(full), 32'd0);
      chk("pend_wr_req", 32'(wr_req), 32'd1);
      chk("pend_data", 32'(fdata), 32'h10);
      step();
      chk("pend_once", 32'(wlog.size()), 32'(n0 + 1));
      chk("pend_word", 32'(wlog[n0]), 32'h10);
      chk("refull_wr_req", 32'(wr_req), 32'd0);
      valid = 4'b0000;
      step();
      chk("full_no_release", 32'(grant), 32'b0001);
      pop_en = 1'b1;
      step(); step();
      chk("full_rel_grant", 32'(grant), 32'd0);
      repeat (8) step();
      chk("drain_count", 32'(rlog.size() - rstart), 32'd9);
      for (int i = 0; i < 9; i++)
         chk("sb_order", 32'(rlog[rstart + i]), 32'(8 + i));

      // 6: reset mid-burst after the 2nd beat
      valid = 4'b0100;
      step(); burst(2, 2, 14, 1'b0);
      srst = 1'b1;
      #1;
      chk("mid_rst_wr_req", 32'(wr_req), 32'd0);
      chk("mid_rst_ready", 32'(ready), 32'd0);
      chk("mid_rst_data", 32'(fdata), 32'd0);
      n0 = wlog.size();
      step();
      chk("mid_rst_grant", 32'(grant), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
      chk("mid_rst_beat", 32'(dut.beat_cnt), 32'd0);
      chk("mid_rst_wlog", 32'(wlog.size()), 32'(n0));
      srst = 1'b0;
      valid = 4'b0000;
      step(); step();
      chk("post_rst_wlog", 32'(wlog.size()), 32'(n0));
      chk("pre_rst_w0", 32'(wlog[n0-2]), 32'h8e);
      chk("pre_rst_w1", 32'(wlog[n0-1]), 32'h8f);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
